// File: rtl/mem_port_arbiter.sv
// Arbitrates one OBI-style memory port between instruction fetch and data
// access. Data wins by default; a bounded data streak forces a fetch grant
// so the core front-end cannot starve. Accepted transactions record their
// requester ID in a small FIFO so in-order responses are routed back.
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int DATA_STREAK_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic [2:0]  outstanding_o,
  output logic        protocol_err_o
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW = $clog2(DATA_STREAK_MAX + 1);
  localparam logic [PW-1:0] PTR_LAST   = PW'(MAX_OUTSTANDING - 1);
  localparam logic [2:0]    CNT_MAX    = 3'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK_MAX);

  typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

  state_t                     state_reg;
  logic [SW-1:0]              streak_reg, streak_next;
  logic [2:0]                 count_reg, count_next;
  logic [PW-1:0]              wr_ptr_reg, rd_ptr_reg;
  logic [MAX_OUTSTANDING-1:0] id_fifo_reg;   // 1 = data, 0 = instruction
  logic [MAX_OUTSTANDING-1:0] slot_we;
  logic                       protocol_err_reg;

  logic mem_req, sel_data, grant, push, pop, head_is_data;

  // Pick who drives the port: the held requester, else a fresh arbitration
  // gated by FIFO space (registered occupancy, so a pop frees a slot only
  // from the following cycle).
  always_comb begin
    mem_req  = 1'b0;
    sel_data = 1'b0;
    unique case (state_reg)
      HOLD_I: mem_req = 1'b1;
      HOLD_D: begin
        mem_req  = 1'b1;
        sel_data = 1'b1;
      end
      default: begin
        if (rst_ni && (count_reg < CNT_MAX)) begin
          mem_req  = instr_req_i | data_req_i;
          sel_data = data_req_i & ~(instr_req_i & (streak_reg == STREAK_MAX));
        end
      end
    endcase
  end

  assign grant = mem_gnt_i & mem_req;
  assign push  = grant;
  assign pop   = rst_ni & mem_rvalid_i & (count_reg != 3'd0);

  assign head_is_data = id_fifo_reg[rd_ptr_reg];

  assign mem_req_o   = mem_req;
  assign mem_we_o    = mem_req & sel_data & data_we_i;
  assign mem_be_o    = !mem_req ? 4'h0  : (sel_data ? data_be_i   : 4'hF);
  assign mem_addr_o  = !mem_req ? 32'h0 : (sel_data ? data_addr_i : instr_addr_i);
  assign mem_wdata_o = (mem_req & sel_data) ? data_wdata_i : 32'h0;

  assign instr_gnt_o = grant & ~sel_data;
  assign data_gnt_o  = grant & sel_data;

  assign instr_rvalid_o = pop & ~head_is_data;
  assign data_rvalid_o  = pop & head_is_data;
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0;
  assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : 32'h0;
  assign instr_err_o    = instr_rvalid_o & mem_err_i;
  assign data_err_o     = data_rvalid_o  & mem_err_i;

  assign outstanding_o  = count_reg;
  assign protocol_err_o = protocol_err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_slot_we
      assign slot_we[gi] = push && (wr_ptr_reg == PW'(gi));
    end
  endgenerate

  // Next streak and occupancy values.
  always_comb begin
    streak_next = streak_reg;
    if (!instr_req_i || instr_gnt_o) begin
      streak_next = '0;
    end else if (data_gnt_o && (streak_reg != STREAK_MAX)) begin
      streak_next = streak_reg + SW'(1);
    end
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 3'd1;
    end else if (!push && pop) begin
      count_next = count_reg - 3'd1;
    end
  end

  // Store the requester ID of each accepted transaction in its FIFO slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_fifo_reg <= '0;
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (slot_we[i]) id_fifo_reg[i] <= sel_data;
      end
    end
  end

  // Hold FSM, FIFO pointers/count, streak counter and sticky protocol error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg        <= IDLE;
      streak_reg       <= '0;
      count_reg        <= 3'd0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      protocol_err_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (mem_req && !mem_gnt_i) state_reg <= sel_data ? HOLD_D : HOLD_I;
        end
        default: begin
          if (mem_gnt_i) state_reg <= IDLE;
        end
      endcase
      streak_reg <= streak_next;
      count_reg  <= count_next;
      if (push) wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PW'(1);
      if (mem_rvalid_i && (count_reg == 3'd0)) protocol_err_reg <= 1'b1;
    end
  end

endmodule
